multicycle_adder: RTL and testbench
===================================

# multicycle_adder

Parametrised add/subtract unit that processes a WIDTH-bit operand pair CHUNK bits per clock. Each chunk uses a ripple of full-adder cells, and a registered carry links one chunk to the next. Operations are launched with a start/busy/done handshake, and results are held until the next completion. The block lets datapaths trade adder area for latency when a single-cycle WIDTH-bit ripple does not meet timing.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK, ≥ 2.
- CHUNK, 4, bits summed per clock; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK is the number of run cycles.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  launch request; sampled only when busy = 0.
- sub  in  1  0: a + b; 1: a − b; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result registers updated.
- sum  out  WIDTH  result, two's-complement wrap.
- c_out  out  1  carry out of the MSB; for subtract, 1 = no borrow (a ≥ b unsigned).
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN.
- IDLE
  - On start = 1, latch A = a and B = (sub ? ~b : b).
  - Set carry = sub, chunk index i = 0, then go to RUN.
- RUN
  - Each cycle, add chunk i of A and B plus carry using CHUNK chained full-adder cells, sum_i = x ^ y ^ c and c_next = (x & y) | ((x ^ y) & c).
  - Write chunk i into the internal result register, register c_next as carry, and increment i.
  - When i = N−1, update sum, c_out and overflow from the final chunk, assert done for one cycle, and return to IDLE.
- overflow uses the carry into bit WIDTH−1, which comes from the ripple inside the final chunk.
- sum, c_out and overflow change only on the done cycle. Between operations they hold the last result.
- start while busy = 1 is ignored. Operands and sub are not re-sampled during RUN.
- Reset (rst_n = 0 at a rising edge) has priority over everything, including mid-operation. It aborts the operation and discards partial results.
  - Next state: IDLE.
  - busy = 0, done = 0, sum = 0, c_out = 0, overflow = 0, internal carry and index = 0.

## Timing
- start sampled at edge k, with busy = 0:
  - busy = 1 from edge k+1 through edge k+N.
  - Chunk i is computed at edge k+1+i.
  - Outputs are updated and done = 1 from edge k+N, for exactly one cycle.
  - busy = 0 in that same cycle.
- Latency is N cycles from the start edge to done. For CHUNK = WIDTH, N = 1, so done follows start by one cycle.
- Back-to-back: start asserted during the done cycle (busy = 0) is accepted. Throughput is one result per N cycles.
- start held high continuously launches a new operation every N cycles, using the operand values present at each accepting edge.
- done and busy are never high together.

## Test plan
- WIDTH=16, CHUNK=4, after reset → all outputs 0. Then start, sub=0, a=0x1234, b=0x0001 → busy for 4 cycles, done pulse 4 cycles after the start edge, sum=0x1235, c_out=0, overflow=0.
- Unsigned wrap and signed overflow:
  - Add a=0xFFFF, b=0x0001 → sum=0x0000, c_out=1, overflow=0.
  - Add a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, overflow=1.
- Subtract:
  - sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0, overflow=0.
  - sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, overflow=1.
- Pulse start again while busy with a=0xAAAA → ignored. The first result completes unchanged. A start in the done cycle is accepted, and its result follows 4 cycles later.
- Drop rst_n for one edge mid-run (cycle 2 of 4) → next cycle busy=0, done=0, sum=0, c_out=0, overflow=0. No done pulse follows.
- Random regression for CHUNK ∈ {1, 4, 16} and WIDTH=16:
  - sum, c_out and overflow must match a reference (a ± b) model.
  - Latency must equal WIDTH/CHUNK.
  - sum must remain stable between done pulses.

Source files
------------

// File: rtl/multicycle_adder.sv
// Chunked ripple add/subtract: sums WIDTH-bit operands CHUNK bits per clock,
// linking chunks through a registered carry, with a start/busy/done handshake.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Handshake: start is accepted on any rising edge where busy = 0 (IDLE);
  // done pulses for one cycle with busy = 0, so a start in that cycle chains.
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] x, y, s;
  logic [CHUNK:0]   c;
  logic             launch, last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    launch = (state == IDLE) && start;
    last   = (state == RUN) && (idx == LAST_IDX);
  end

  // One chunk of full-adder cells; c[CHUNK-1] is the carry into the chunk's top bit.
  always_comb begin
    x    = op_a[int'(idx)*CHUNK +: CHUNK];
    y    = op_b[int'(idx)*CHUNK +: CHUNK];
    s    = '0;
    c    = '0;
    c[0] = carry;
    for (int j = 0; j < CHUNK; j++) begin
      s[j]   = x[j] ^ y[j] ^ c[j];
      c[j+1] = (x[j] & y[j]) | ((x[j] ^ y[j]) & c[j]);
    end
    acc_nxt = acc;
    acc_nxt[int'(idx)*CHUNK +: CHUNK] = s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        carry <= sub;
        idx   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nxt;
        carry <= c[CHUNK];
        idx   <= last ? '0 : idx + IDX_W'(1);
        if (last) begin
          sum      <= acc_nxt;
          c_out    <= c[CHUNK];
          overflow <= c[CHUNK] ^ c[CHUNK-1];
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: directed cases on CHUNK=4, then random traffic on
// CHUNK = 1, 4 and 16 instances scored against an arithmetic reference.
module tb_multicycle_adder;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sub = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2:0]     start_v = '0;
  logic [2:0]     busy_v, done_v, cout_v, ov_v;
  logic [W-1:0]   sum_v [3];
  logic [W-1:0]   last_sum [3];
  int             lat_of [3];

  logic [W+1:0]   exp_q [$];
  int             checks = 0;
  int             errors = 0;

  multicycle_adder #(.WIDTH(W), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .c_out(cout_v[0]), .overflow(ov_v[0]));

  multicycle_adder #(.WIDTH(W), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .c_out(cout_v[1]), .overflow(ov_v[1]));

  multicycle_adder #(.WIDTH(W), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .c_out(cout_v[2]), .overflow(ov_v[2]));

  // clock
  always #5 clk = ~clk;

  // Reference: {c_out, overflow, sum} from plain unsigned/signed arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                             input logic s);
    logic [W:0]   r;
    logic [W-1:0] res;
    logic         co, ov;
    if (!s) begin
      r   = {1'b0, aa} + {1'b0, bb};
      res = r[W-1:0];
      co  = r[W];
      ov  = (aa[W-1] == bb[W-1]) && (res[W-1] != aa[W-1]);
    end else begin
      res = aa - bb;
      co  = (aa >= bb);
      ov  = (aa[W-1] != bb[W-1]) && (res[W-1] != aa[W-1]);
    end
    return {co, ov, res};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one accepting edge and queues the expected result.
  task automatic launch(input int d, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic s, input logic [W+1:0] e);
    a = aa;
    b = bb;
    sub = s;
    start_v[d] = 1'b1;
    exp_q.push_back(e);
    tick();
    start_v[d] = 1'b0;
    chk("done_one_cycle", {31'd0, done_v[d]}, 32'd0);
  endtask

  // Waits for done with a cycle budget; optionally pokes start while busy.
  task automatic wait_done(input int d, input int poke);
    int cyc;
    logic [W+1:0] e;
    cyc = 0;
    while (done_v[d] !== 1'b1 && cyc < lat_of[d] + 4) begin
      chk("busy_run", {31'd0, busy_v[d]}, 32'd1);
      chk("sum_stable_run", {16'd0, sum_v[d]}, {16'd0, last_sum[d]});
      if (cyc == poke) begin
        a = 16'hAAAA;
        b = 16'hAAAA;
        start_v[d] = 1'b1;
      end
      tick();
      start_v[d] = 1'b0;
      cyc++;
    end
    chk("latency", cyc, lat_of[d]);
    chk("busy_in_done", {31'd0, busy_v[d]}, 32'd0);
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("sum", {16'd0, sum_v[d]}, {16'd0, e[W-1:0]});
      chk("c_out", {31'd0, cout_v[d]}, {31'd0, e[W+1]});
      chk("overflow", {31'd0, ov_v[d]}, {31'd0, e[W]});
    end
    last_sum[d] = sum_v[d];
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_done", {31'd0, done_v[d]}, 32'd0);
      chk("sum_stable_idle", {16'd0, sum_v[d]}, {16'd0, last_sum[d]});
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    lat_of[0] = 4;
    lat_of[1] = 16;
    lat_of[2] = 1;

    // reset
    tick();
    tick();
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", {31'd0, busy_v[d]}, 32'd0);
      chk("rst_done", {31'd0, done_v[d]}, 32'd0);
      chk("rst_sum", {16'd0, sum_v[d]}, 32'd0);
      chk("rst_c_out", {31'd0, cout_v[d]}, 32'd0);
      chk("rst_overflow", {31'd0, ov_v[d]}, 32'd0);
      last_sum[d] = '0;
    end

    // directed cases, chained back-to-back through the done cycle
    launch(0, 16'h1234, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h1235});
    wait_done(0, -1);
    launch(0, 16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h0000});
    wait_done(0, -1);
    launch(0, 16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h8000});
    wait_done(0, -1);
    launch(0, 16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    wait_done(0, -1);
    launch(0, 16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    wait_done(0, -1);
    idle(0, 2);

    // start while busy is ignored; start in the done cycle is accepted
    launch(0, 16'h1111, 16'h2222, 1'b0, {1'b0, 1'b0, 16'h3333});
    wait_done(0, 1);
    launch(0, 16'h4000, 16'h0123, 1'b1, {1'b1, 1'b0, 16'h3EDD});
    wait_done(0, -1);
    idle(0, 1);

    // reset mid-run aborts and no done follows
    launch(0, 16'h0F0F, 16'h0101, 1'b0, {1'b0, 1'b0, 16'h1010});
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("abort_done", {31'd0, done_v[0]}, 32'd0);
    chk("abort_sum", {16'd0, sum_v[0]}, 32'd0);
    chk("abort_c_out", {31'd0, cout_v[0]}, 32'd0);
    chk("abort_overflow", {31'd0, ov_v[0]}, 32'd0);
    for (int d = 0; d < 3; d++) last_sum[d] = '0;
    idle(0, 6);

    // random regression on each chunk size
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 20; k++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rs = 1'($urandom_range(0, 1));
        if (k == 0) begin
          ra = 16'h7FFF;
          rb = 16'h8000;
          rs = 1'b1;
        end
        launch(d, ra, rb, rs, ref_model(ra, rb, rs));
        wait_done(d, (k % 5 == 2) ? 0 : -1);
        if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(1, 2));
      end
    end

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
